// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: word width, NOP encoding,
// fetch FSM states and the {pc, instr} entry stored in the prefetch FIFO.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Synchronous FIFO with push/pop/clear and occupancy reporting.
// Read is combinational from the head slot; DEPTH must be a power of 2.
module riscv_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PW+1)'(DEPTH));
    assign do_pop    = pop && !empty && !clear;
    assign do_push   = push && !clear && (!full || do_pop);
    assign head_data = storage[rd_ptr];

    // Pointer and occupancy bookkeeping; clear empties the queue in one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Entry storage; contents only matter where count marks them valid.
    always_ff @(posedge clk) begin
        if (do_push) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_fetch_prefetch.sv
// Instruction fetch stage: issues word fetches, buffers in-order responses
// tagged with their PC, and hands one {pc, instr} per cycle downstream.
// A redirect flushes buffered work and drops responses already in flight.
module riscv_fetch_prefetch
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr,
    output logic [2:0]      stale_cnt_out
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [CW-1:0]   inflight;
    logic [CW-1:0]   inflight_next;
    logic [CW-1:0]   stale;
    logic [CW-1:0]   stale_dec;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     occ_total;
    logic            fifo_full;
    logic            fifo_empty;
    logic            req_fire;
    logic            rsp_seen;
    logic            rsp_push;
    logic            head_pop;
    logic [XLEN-1:0] target_pc;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    assign target_pc  = redirect_pc & ~32'h3;
    assign occ_total  = {1'b0, fifo_count} + {1'b0, inflight};
    assign rsp_seen   = imem_rsp_valid && (inflight != '0);
    assign rsp_push   = rsp_seen && (state == RUN) && !redirect_valid;
    assign head_pop   = out_valid && out_ready && !redirect_valid;
    assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

    assign imem_req_valid = (state == RUN) && !redirect_valid && !fifo_full
                            && (occ_total < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign out_valid     = !fifo_empty;
    assign out_pc        = out_valid ? head_entry.pc : '0;
    assign out_instr     = out_valid ? head_entry.instr : NOP_INSTR;
    assign stale_cnt_out = 3'(stale);

    // Next outstanding-request count: one up per fired request, one down per response.
    always_comb begin
        inflight_next = inflight;
        if (req_fire && !rsp_seen)      inflight_next = inflight + 1'b1;
        else if (!req_fire && rsp_seen) inflight_next = inflight - 1'b1;
    end

    // Stale counter after this cycle's response, used while draining a flush.
    always_comb begin
        stale_dec = stale;
        if (rsp_seen && (stale != '0)) stale_dec = stale - 1'b1;
    end

    // Fetch FSM plus the PC and in-flight bookkeeping; redirect overrides everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            inflight <= '0;
            stale    <= '0;
        end else begin
            inflight <= inflight_next;
            if (req_fire) fetch_pc <= fetch_pc + 32'd4;
            if (rsp_push) rsp_pc   <= rsp_pc + 32'd4;
            case (state)
                BOOT:    state <= RUN;
                RUN:     if (redirect_valid && (inflight != '0)) state <= FLUSH;
                FLUSH: begin
                    stale <= stale_dec;
                    if (!redirect_valid && (stale_dec == '0)) state <= RUN;
                end
                default: state <= BOOT;
            endcase
            if (redirect_valid) begin
                fetch_pc <= target_pc;
                rsp_pc   <= target_pc;
                stale    <= rsp_seen ? inflight - 1'b1 : inflight;
            end
        end
    end

    riscv_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (head_pop),
        .clear     (redirect_valid),
        .head_data (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_riscv_fetch_prefetch.sv
// Bench for the fetch/prefetch stage: a latency-programmable in-order memory
// model, logs of issued addresses and consumed {pc, instr}, and per-scenario
// tasks comparing those logs against the expected sequential PC stream.
module tb_riscv_fetch_prefetch;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  stale_cnt_out;

    int checks   = 0;
    int failures = 0;

    int          cyc;
    int          lat;
    int          ready_mode;
    int          first_valid_cyc;
    int          max_out;
    int          pre_out;
    logic        last_rsp;
    logic        last_req_valid;
    logic [2:0]  last_stale;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] req_log[$];
    logic [31:0] obs_pc[$];
    logic [31:0] obs_instr[$];

    riscv_fetch_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .stale_cnt_out  (stale_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'h5A5A_0000) * 32'h0001_0003) + 32'h13;
    endfunction

    task automatic clear_logs();
        req_log.delete();
        obs_pc.delete();
        obs_instr.delete();
        first_valid_cyc = -1;
    endtask

    // One clock cycle: memory drives its due response, DUT is sampled at negedge.
    task automatic tick();
        pre_out = mq_addr.size();
        if (pre_out > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        last_rsp = imem_rsp_valid;
        case (ready_mode)
            0:       imem_req_ready = 1'b1;
            1:       imem_req_ready = 1'($urandom_range(0, 1));
            default: imem_req_ready = 1'b0;
        endcase
        @(negedge clk);
        last_req_valid = imem_req_valid;
        last_stale     = stale_cnt_out;
        if (imem_req_valid && imem_req_ready) begin
            req_log.push_back(imem_req_addr);
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(cyc + lat);
        end
        if (mq_addr.size() > max_out) max_out = mq_addr.size();
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid && out_ready && !redirect_valid) begin
            obs_pc.push_back(out_pc);
            obs_instr.push_back(out_instr);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reset the DUT and memory together, then release at posedge+1 (cycle 0 = BOOT).
    task automatic start_run(input int latency);
        reset          = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        mq_addr.delete();
        mq_due.delete();
        clear_logs();
        max_out = 0;
        lat = latency;
        ready_mode = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h exp=0", imem_req_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
        checks++; if (out_instr !== 32'h00000013) begin failures++; $display("FAIL reset_out_instr got=%h exp=00000013", out_instr); end
        checks++; if (stale_cnt_out !== 3'd0) begin failures++; $display("FAIL reset_stale got=%0d exp=0", stale_cnt_out); end
    endtask

    task automatic test_stream();
        start_run(1);
        out_ready = 1'b1;
        tick();
        checks++; if (last_req_valid !== 1'b0) begin failures++; $display("FAIL boot_no_req got=%b exp=0", last_req_valid); end
        repeat (23) tick();
        checks++; if (first_valid_cyc !== 3) begin failures++; $display("FAIL stream_first_valid got=%0d exp=3", first_valid_cyc); end
        checks++; if (obs_pc.size() < 18) begin failures++; $display("FAIL stream_pop_count got=%0d exp>=18", obs_pc.size()); end
        for (int i = 0; i < req_log.size(); i++) begin
            checks++; if (req_log[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", i, req_log[i], 32'(4 * i)); end
        end
        for (int i = 0; i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, obs_pc[i], 32'(4 * i)); end
            checks++; if (obs_instr[i] !== mem_word(32'(4 * i))) begin failures++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, obs_instr[i], mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_backpressure();
        start_run(1);
        out_ready = 1'b0;
        repeat (10) tick();
        checks++; if (req_log.size() != 4) begin failures++; $display("FAIL bp_req_count got=%0d exp=4", req_log.size()); end
        checks++; if (last_req_valid !== 1'b0) begin failures++; $display("FAIL bp_req_valid got=%b exp=0", last_req_valid); end
        out_ready = 1'b1;
        repeat (4) tick();
        checks++; if (obs_pc.size() < 4) begin failures++; $display("FAIL bp_pop_count got=%0d exp>=4", obs_pc.size()); end
        for (int i = 0; i < 4 && i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== 32'(4 * i)) begin failures++; $display("FAIL bp_pc[%0d] got=%h exp=%h", i, obs_pc[i], 32'(4 * i)); end
        end
    endtask

    task automatic test_redirect_flush();
        int exp_stale;
        start_run(4);
        out_ready = 1'b1;
        repeat (3) tick();
        ready_mode = 2;
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        tick();
        exp_stale = pre_out - int'(last_rsp);
        redirect_valid = 1'b0;
        ready_mode = 0;
        tick();
        checks++; if (int'(last_stale) != exp_stale) begin failures++; $display("FAIL flush_stale got=%0d exp=%0d", last_stale, exp_stale); end
        checks++; if (last_req_valid !== 1'b0) begin failures++; $display("FAIL flush_req_valid got=%b exp=0", last_req_valid); end
        repeat (24) tick();
        checks++; if (req_log.size() == 0 || req_log[0] !== 32'h100) begin failures++; $display("FAIL flush_first_addr got=%h exp=00000100", req_log.size() ? req_log[0] : 32'hx); end
        checks++; if (obs_pc.size() < 8) begin failures++; $display("FAIL flush_pop_count got=%0d exp>=8", obs_pc.size()); end
        for (int i = 0; i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== 32'h100 + 32'(4 * i)) begin failures++; $display("FAIL flush_pc[%0d] got=%h exp=%h", i, obs_pc[i], 32'h100 + 32'(4 * i)); end
            checks++; if (obs_instr[i] !== mem_word(32'h100 + 32'(4 * i))) begin failures++; $display("FAIL flush_instr[%0d] got=%h", i, obs_instr[i]); end
        end
    endtask

    task automatic test_redirect_align();
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        checks++; if (req_log.size() == 0 || req_log[0] !== 32'h200) begin failures++; $display("FAIL align_addr got=%h exp=00000200", req_log.size() ? req_log[0] : 32'hx); end
        checks++; if (obs_pc.size() == 0 || obs_pc[0] !== 32'h200) begin failures++; $display("FAIL align_pc got=%h exp=00000200", obs_pc.size() ? obs_pc[0] : 32'hx); end
        clear_logs();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick();
        redirect_pc    = 32'h80;
        tick();
        redirect_valid = 1'b0;
        repeat (20) tick();
        checks++; if (req_log.size() == 0 || req_log[0] !== 32'h80) begin failures++; $display("FAIL b2b_addr got=%h exp=00000080", req_log.size() ? req_log[0] : 32'hx); end
        checks++; if (obs_pc.size() < 4) begin failures++; $display("FAIL b2b_pop_count got=%0d exp>=4", obs_pc.size()); end
        for (int i = 0; i < obs_pc.size(); i++) begin
            checks++; if (obs_pc[i] !== 32'h80 + 32'(4 * i)) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, obs_pc[i], 32'h80 + 32'(4 * i)); end
        end
    endtask

    task automatic test_random();
        logic [31:0] seg_base;
        logic [31:0] target;
        int          total_pops;
        int          seg_bad;
        start_run(3);
        ready_mode = 1;
        seg_base   = 32'h0;
        total_pops = 0;
        for (int n = 0; n <= 500; n++) begin
            if (n == 500 || $urandom_range(0, 39) == 0) begin
                seg_bad = 0;
                for (int i = 0; i < obs_pc.size(); i++) begin
                    if (obs_pc[i] !== seg_base + 32'(4 * i) || obs_instr[i] !== mem_word(seg_base + 32'(4 * i))) begin
                        if (seg_bad == 0) $display("FAIL rand_pc[%0d] got=%h/%h exp=%h", i, obs_pc[i], obs_instr[i], seg_base + 32'(4 * i));
                        seg_bad++;
                    end
                end
                for (int i = 0; i < req_log.size(); i++) begin
                    if (req_log[i] !== seg_base + 32'(4 * i)) begin
                        if (seg_bad == 0) $display("FAIL rand_addr[%0d] got=%h exp=%h", i, req_log[i], seg_base + 32'(4 * i));
                        seg_bad++;
                    end
                end
                checks++; if (seg_bad != 0) failures++;
                total_pops += obs_pc.size();
                if (n == 500) break;
                clear_logs();
                target = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31)) : 32'($urandom);
                seg_base = target & ~32'h3;
                redirect_valid = 1'b1;
                redirect_pc    = target;
            end
            out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
            redirect_valid = 1'b0;
        end
        checks++; if (max_out > 4) begin failures++; $display("FAIL rand_inflight got=%0d exp<=4", max_out); end
        checks++; if (total_pops < 40) begin failures++; $display("FAIL rand_pops got=%0d exp>=40", total_pops); end
    endtask

    task automatic test_reset_mid_flush();
        int exp_stale;
        start_run(6);
        out_ready = 1'b1;
        repeat (3) tick();
        ready_mode = 2;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        exp_stale = pre_out - int'(last_rsp);
        redirect_valid = 1'b0;
        tick();
        #2;
        checks++; if (int'(stale_cnt_out) != exp_stale || exp_stale == 0) begin failures++; $display("FAIL midflush_stale got=%0d exp=%0d", stale_cnt_out, exp_stale); end
        reset = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL midrst_req_valid got=%b exp=0", imem_req_valid); end
        checks++; if (imem_req_addr !== 32'h0) begin failures++; $display("FAIL midrst_req_addr got=%h exp=0", imem_req_addr); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_instr !== 32'h00000013) begin failures++; $display("FAIL midrst_out_instr got=%h exp=00000013", out_instr); end
        checks++; if (stale_cnt_out !== 3'd0) begin failures++; $display("FAIL midrst_stale got=%0d exp=0", stale_cnt_out); end
        start_run(1);
        out_ready = 1'b1;
        repeat (12) tick();
        checks++; if (req_log.size() == 0 || req_log[0] !== 32'h0) begin failures++; $display("FAIL restart_addr got=%h exp=0", req_log.size() ? req_log[0] : 32'hx); end
        checks++; if (obs_pc.size() == 0 || obs_pc[0] !== 32'h0) begin failures++; $display("FAIL restart_pc got=%h exp=0", obs_pc.size() ? obs_pc[0] : 32'hx); end
        checks++; if (first_valid_cyc !== 3) begin failures++; $display("FAIL restart_latency got=%0d exp=3", first_valid_cyc); end
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        cyc            = 0;
        lat            = 1;
        ready_mode     = 0;
        max_out        = 0;
        pre_out        = 0;
        last_rsp       = 1'b0;
        clear_logs();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_flush();
        test_redirect_align();
        test_random();
        test_reset_mid_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
